// File: rtl/s2p_load_ctrl.sv
// s2p_load_ctrl: serial-to-parallel load controller.
// Assembles 2**N serial bits and pulses load_en into the DFF bank.
// Ports: clk, rst_n (async low), sin/sin_valid/sync serial input,
//   par_out/load_en to the bank, word_valid/word_ready handshake,
//   busy, bit_cnt, sticky overrun/frame_err, clr_err.
module s2p_load_ctrl #(
   parameter int N         = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sin,
   input  logic              sin_valid,
   input  logic              sync,
   output logic [2**N-1:0]   par_out,
   output logic              load_en,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              busy,
   output logic [N-1:0]      bit_cnt,
   output logic              overrun,
   output logic              frame_err,
   input  logic              clr_err
);

   localparam int W = 2**N;
   localparam logic [N-1:0] CNT_MAX = '1;
   localparam logic [N-1:0] CNT_ONE = N'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_t;

   state_t         state;
   state_t         state_n;
   logic [W-1:0]   sr;
   logic [W-1:0]   sr_n;
   logic [N-1:0]   cnt_n;
   logic           ovr_n;
   logic           ferr_n;
   logic           wv_n;
   logic           shift_in;
   logic           bank_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sr         <= '0;
         bit_cnt    <= '0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
         word_valid <= 1'b0;
      end else begin
         state      <= state_n;
         sr         <= sr_n;
         bit_cnt    <= cnt_n;
         overrun    <= ovr_n;
         frame_err  <= ferr_n;
         word_valid <= wv_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = bit_cnt;
      shift_in  = 1'b0;
      load_en   = 1'b0;
      bank_free = ~word_valid | word_ready;
      // Set events below override the clear.
      ovr_n     = overrun & ~clr_err;
      ferr_n    = frame_err & ~clr_err;
      unique case (state)
         IDLE: begin
            if (sin_valid && sync) begin
               shift_in = 1'b1;
               cnt_n    = CNT_ONE;
               state_n  = SHIFT;
            end
         end
         SHIFT: begin
            if (sin_valid) begin
               shift_in = 1'b1;
               if (sync) begin
                  // Resync: this bit starts a new frame.
                  ferr_n = 1'b1;
                  cnt_n  = CNT_ONE;
               end else if (bit_cnt == CNT_MAX) begin
                  cnt_n   = '0;
                  state_n = LOAD;
               end else begin
                  cnt_n = bit_cnt + CNT_ONE;
               end
            end
         end
         LOAD: begin
            // sr is frozen here, so any incoming bit is lost.
            if (sin_valid) ovr_n = 1'b1;
            if (bank_free) begin
               load_en = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (load_en) wv_n = 1'b1;
      else if (word_ready) wv_n = 1'b0;
      else wv_n = word_valid;

      sr_n = sr;
      if (shift_in) begin
         if (MSB_FIRST) sr_n = {sr[W-2:0], sin};
         else sr_n = {sin, sr[W-1:1]};
      end
   end

   assign par_out = sr;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_s2p_load_ctrl.sv
// tb_s2p_load_ctrl: scoreboard bench for s2p_load_ctrl.
// Runs MSB-first and LSB-first instances on one shared bit stream.
module tb_s2p_load_ctrl;

   localparam int N = 4;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic sin = 1'b0;
   logic sin_valid = 1'b0;
   logic sync = 1'b0;
   logic word_ready = 1'b0;
   logic clr_err = 1'b0;

   logic [W-1:0] par1, par0;
   logic         le1, le0, wv1, wv0, busy1, busy0;
   logic [N-1:0] cnt1, cnt0;
   logic         ovr1, ovr0, fe1, fe0;

   int vectors = 0;
   int miscompares = 0;

   s2p_load_ctrl #(.N(N), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
      .sync(sync), .par_out(par1), .load_en(le1), .word_valid(wv1),
      .word_ready(word_ready), .busy(busy1), .bit_cnt(cnt1),
      .overrun(ovr1), .frame_err(fe1), .clr_err(clr_err)
   );

   s2p_load_ctrl #(.N(N), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
      .sync(sync), .par_out(par0), .load_en(le0), .word_valid(wv0),
      .word_ready(word_ready), .busy(busy0), .bit_cnt(cnt0),
      .overrun(ovr0), .frame_err(fe0), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   // Reference model: frame bits held in a queue, words built arithmetically.
   typedef struct {
      logic [W-1:0] w1;
      logic [W-1:0] w0;
   } exp_t;

   exp_t sbq[$];
   bit   m_bits[$];
   bit   m_col, m_pend, m_wv, m_ovr, m_ferr, m_le;

   function automatic exp_t build_word();
      exp_t e;
      e.w1 = '0;
      e.w0 = '0;
      for (int i = 0; i < W; i++) begin
         if (m_bits[i]) begin
            e.w1 = e.w1 + (W'(1) << (W - 1 - i));
            e.w0 = e.w0 + (W'(1) << i);
         end
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_col = 0; m_pend = 0; m_wv = 0;
         m_ovr = 0; m_ferr = 0;
         m_bits.delete();
         sbq.delete();
      end else begin
         m_le = m_pend && (!m_wv || word_ready);
         if (clr_err) begin
            m_ovr = 0;
            m_ferr = 0;
         end
         if (m_pend) begin
            if (sin_valid) m_ovr = 1;
            if (m_le) m_pend = 0;
         end else if (m_col) begin
            if (sin_valid) begin
               if (sync) begin
                  m_ferr = 1;
                  m_bits.delete();
               end
               m_bits.push_back(sin);
               if (m_bits.size() == W) begin
                  sbq.push_back(build_word());
                  m_bits.delete();
                  m_col = 0;
                  m_pend = 1;
               end
            end
         end else if (sin_valid && sync) begin
            m_col = 1;
            m_bits.delete();
            m_bits.push_back(sin);
         end
         if (m_le) m_wv = 1;
         else if (word_ready) m_wv = 0;
      end
   end

   // Per-cycle status check of both instances.
   logic [8:0] exp_st, act1, act0;
   always @(negedge clk) begin
      exp_st = {m_col || m_pend, m_wv, m_ovr, m_ferr,
                m_col ? N'(m_bits.size()) : N'(0),
                m_pend && (!m_wv || word_ready)};
      act1 = {busy1, wv1, ovr1, fe1, cnt1, le1};
      act0 = {busy0, wv0, ovr0, fe0, cnt0, le0};
      vectors++;
      if (act1 !== exp_st) begin
         miscompares++;
         $display("FAIL status_msb t=%0t got=%b want=%b", $time, act1, exp_st);
      end
      vectors++;
      if (act0 !== exp_st) begin
         miscompares++;
         $display("FAIL status_lsb t=%0t got=%b want=%b", $time, act0, exp_st);
      end
   end

   // Scoreboard monitor: each load pulse must present the next word.
   exp_t e;
   always @(negedge clk) begin
      if (le1 === 1'b1) begin
         vectors++;
         if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL load_no_word t=%0t par=%h", $time, par1);
         end else begin
            e = sbq.pop_front();
            if (par1 !== e.w1 || par0 !== e.w0) begin
               miscompares++;
               $display("FAIL par_out t=%0t got=%h/%h want=%h/%h",
                        $time, par1, par0, e.w1, e.w0);
            end
         end
      end
   end

   task automatic cyc(input bit v, input bit s, input bit y,
                      input bit r, input bit c);
      sin_valid = v;
      sin = s;
      sync = y;
      word_ready = r;
      clr_err = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit r);
      for (int i = 0; i < W; i++) cyc(1'b1, w[W-1-i], i == 0, r, 1'b0);
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, r, 1'b0);
   endtask

   task automatic async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({par1, par0, le1, le0, wv1, wv0, busy1, busy0,
           cnt1, cnt0, ovr1, ovr0, fe1, fe0} !== '0) begin
         miscompares++;
         $display("FAIL async_reset par=%h/%h wv=%b busy=%b cnt=%0d",
                  par1, par0, wv1, busy1, cnt1);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [W-1:0] w;

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2, 1'b1);

      // Basic frame, downstream always ready.
      send_word(16'hA5C3, 1'b1);
      idle(4, 1'b1);

      // Back-to-back frames with downstream stalled, then overrun.
      send_word(16'h1234, 1'b0);
      idle(1, 1'b0);
      send_word(16'hBEEF, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b1);
      idle(3, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Mid-frame sync at bit 7.
      w = 16'h5A0F;
      for (int i = 0; i < 7; i++) cyc(1'b1, w[W-1-i], i == 0, 1'b1, 1'b0);
      send_word(16'h8001, 1'b1);
      idle(2, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      // clr_err together with a resync: set wins.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, i == 0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 15; i++) cyc(1'b1, i[0], 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // Unsynced bits in IDLE are ignored.
      for (int i = 0; i < 20; i++) cyc(1'b1, i[1], 1'b0, 1'b1, 1'b0);

      // Async reset 3 bits into a frame while a word is pending.
      send_word(16'hC0DE, 1'b0);
      idle(1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
      async_reset();
      send_word(16'h3C96, 1'b1);
      idle(3, 1'b1);

      // Boundary words.
      send_word(16'hFFFF, 1'b1);
      idle(1, 1'b1);
      send_word(16'h0000, 1'b1);
      idle(3, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 29) == 0);

      // Random full frames with random stalls.
      for (int k = 0; k < 40; k++) begin
         w = W'($urandom);
         send_word(w, $urandom_range(0, 1) == 1);
         idle($urandom_range(1, 3), $urandom_range(0, 1) == 1);
      end

      idle(25, 1'b1);
      vectors++;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL drain left=%0d want=0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/s2p_load_ctrl.md
Name: s2p_load_ctrl

Overview:
- Controller for the serial-to-parallel (S2P) path.
- Assembles 2**N serial bits into a shift register and sequences the one-cycle enable pulse into the 2**N-bit clock-enabled DFF bank.
- Tracks whether the bank's word has been consumed, using a valid/ready handshake.
- Flags overrun and framing errors. Sits between the serial front end and the bank's `a`/`en` inputs.

Parameters:
- N, 4: word width is 2**N bits (default 16); bit counter is N bits wide.
- MSB_FIRST, 1: 1 = first received bit lands in par_out[2**N-1]; 0 = first bit lands in par_out[0].

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is valid this cycle.
- sync  input  1  start of frame; qualified by sin_valid; the bit accepted with it is frame bit 0.
- par_out  output  2**N  assembled shift-register contents; drives the bank `a` input.
- load_en  output  1  one-cycle enable to the bank `en` input.
- word_valid  output  1  bank holds an unconsumed word.
- word_ready  input  1  downstream consumes the bank word.
- busy  output  1  high in SHIFT or LOAD.
- bit_cnt  output  N  bits accepted in the current frame, modulo 2**N.
- overrun  output  1  sticky: a serial bit was dropped.
- frame_err  output  1  sticky: sync arrived mid-frame.
- clr_err  input  1  clears overrun and frame_err.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; par_out=0, load_en=0, word_valid=0, busy=0, bit_cnt=0, overrun=0, frame_err=0. A partial frame is discarded. A pending word is forgotten (word_valid=0).
- Shift rule, applied on every accepted bit:
  - MSB_FIRST=1: sr <= {sr[2**N-2:0], sin}.
  - MSB_FIRST=0: sr <= {sin, sr[2**N-1:1]}.
  - par_out is the register sr itself, i.e. registered, no combinational path from sin.
- FSM states:
  - IDLE:
    - sin_valid & sync: shift in the bit, bit_cnt=1, go to SHIFT.
    - sin_valid without sync: bit ignored; not an error.
  - SHIFT:
    - Each sin_valid shifts in sin and increments bit_cnt.
    - If the bit arrives with sync: frame_err<=1, bit_cnt<=1; that bit becomes bit 0 of the new frame (resync).
    - On the accepted bit with bit_cnt==2**N-1 and no sync: bit_cnt wraps to 0, go to LOAD.
  - LOAD:
    - Bank is free when word_valid==0 or word_ready==1 this cycle. If free: load_en=1 (combinational from state and bank-free), go to IDLE.
    - Otherwise stay in LOAD with load_en=0, waiting for downstream.
    - Any sin_valid while in LOAD: bit dropped, overrun<=1, sr unchanged.
- Latency:
  - 16th bit accepted at edge T → LOAD during cycle T+1.
  - With the bank free, load_en=1 in cycle T+1, the bank captures at edge T+2, and word_valid=1 from T+2.
  - Minimum inter-frame gap: the next sync bit can be accepted in cycle T+2 (IDLE).
- word_valid:
  - Set on load_en.
  - Cleared on word_valid & word_ready when load_en=0.
  - load_en and word_ready in the same cycle: stays 1 (old word consumed, new word loaded).
- Sticky flags: clr_err clears both. If a set event and clr_err occur in the same cycle, set wins.
- busy = (state != IDLE).
- Outputs never X after reset; load_en is never high for two consecutive cycles.

Test Plan:
- Reset, then 16 bits of 0xA5C3 MSB-first with sync on the first bit, word_ready=1 → load_en pulses one cycle, one cycle after the last bit; par_out=0xA5C3 during the pulse; word_valid=1 next cycle then 0; overrun=0, frame_err=0.
- MSB_FIRST=0, same bit stream → par_out=0xC3A5 (bit-reversed); bit_cnt sequence 1..15,0.
- word_ready=0, two back-to-back frames → first word loaded, word_valid=1. Second frame waits in LOAD, load_en=0. Bits sent during LOAD set overrun=1. Raising word_ready gives load_en in that same cycle; word_valid stays 1.
- sync asserted at bit 7 of a frame → frame_err=1, bit_cnt=1. Load occurs only after 16 bits counted from the new sync. clr_err together with a new mid-frame sync leaves frame_err=1.
- sin_valid without sync in IDLE for 20 cycles → no state change, busy=0, no flags.
- rst_n pulsed low for 3 bits into a frame and while word_valid=1 → all outputs 0 immediately (async); next frame after reset assembles correctly.
